// File: rtl/wb_tcam_pkg.sv
// Shared types and sizing helpers for the ternary match table.
// No logic, no latency.
// No flow control.
package wb_tcam_pkg;

    // Controller phase: sweep-clear of valid bits, then normal operation.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Number of table entries addressable with a given address width.
    function automatic int tcam_items(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/wb_tcam_write_ctrl_if.sv
// Write Bus plus lookup port of the ternary match table.
// No logic, no latency.
// Writes use SRC_RDY/DST_RDY handshake; lookups have no backpressure.
interface wb_tcam_write_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
);
    import wb_tcam_pkg::*;

    localparam int ITEMS = tcam_items(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] WB_DATA;
    logic [DATA_WIDTH-1:0] WB_MASK;
    logic [ADDR_WIDTH-1:0] WB_ADDR;
    logic                  WB_SRC_RDY;
    logic                  WB_DST_RDY;
    logic [DATA_WIDTH-1:0] MATCH_KEY;
    logic                  MATCH_REQ;
    logic                  MATCH_VLD;
    logic                  MATCH_HIT;
    logic [ITEMS-1:0]      MATCH_OUT;

    modport master (
        output WB_DATA, WB_MASK, WB_ADDR, WB_SRC_RDY, MATCH_KEY, MATCH_REQ,
        input  WB_DST_RDY, MATCH_VLD, MATCH_HIT, MATCH_OUT
    );

    modport slave (
        input  WB_DATA, WB_MASK, WB_ADDR, WB_SRC_RDY, MATCH_KEY, MATCH_REQ,
        output WB_DST_RDY, MATCH_VLD, MATCH_HIT, MATCH_OUT
    );

endinterface

// File: rtl/wb_tcam_entry.sv
// One ternary entry: value, care-mask and valid bit with a combinational hit.
// Storage updates on the clock edge; hit is combinational from stored state.
// No flow control; the controller decides when to write or clear.
module wb_tcam_entry #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] key,
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic                  valid_q;

    // Value and mask are plain storage; they are meaningless until valid is set.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_q <= wr_data;
            mask_q <= wr_mask;
        end
    end

    // Clearing wins over a write so the sweep always leaves the entry invalid.
    always_ff @(posedge CLK) begin
        if (clr) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
        end
    end

    // Only cared-for bits may differ; an all-zero mask matches any key.
    assign hit = valid_q & ~|((key ^ data_q) & mask_q);

endmodule

// File: rtl/wb_tcam_write_ctrl.sv
// Ternary match table written over the Write Bus, looked up one key per cycle.
// Lookup result registered one cycle after the request; writes take effect on the accepting edge.
// DST_RDY low during the post-reset clear sweep; lookups never backpressure.
module wb_tcam_write_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    wb_tcam_write_ctrl_if.slave  wb
);
    import wb_tcam_pkg::*;

    localparam int ITEMS = tcam_items(ADDR_WIDTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  dst_rdy_q;
    logic                  match_vld_q;
    logic                  match_hit_q;
    logic [ITEMS-1:0]      match_out_q;
    logic [ITEMS-1:0]      hit_vec;
    logic [ITEMS-1:0]      wr_en;
    logic [ITEMS-1:0]      clr_en;
    logic                  wr_fire;

    // A write is only taken when the registered ready was shown and reset is not active.
    assign wr_fire = wb.WB_SRC_RDY & dst_rdy_q & RESET;

    // Entry array: decoded write enables and the sweep clear select one entry each.
    for (genvar i = 0; i < ITEMS; i++) begin : g_entry
        assign wr_en[i]  = wr_fire && (wb.WB_ADDR == ADDR_WIDTH'(i));
        assign clr_en[i] = (state == INIT) && (clr_cnt == ADDR_WIDTH'(i));

        wb_tcam_entry #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_entry (
            .CLK     (CLK),
            .wr_en   (wr_en[i]),
            .clr     (clr_en[i]),
            .wr_data (wb.WB_DATA),
            .wr_mask (wb.WB_MASK),
            .key     (wb.MATCH_KEY),
            .hit     (hit_vec[i])
        );
    end

    // Controller: clear sweep, ready flag and registered lookup results.
    // Lookups sample the table before any same-edge write lands.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= INIT;
            clr_cnt     <= '0;
            dst_rdy_q   <= 1'b0;
            match_vld_q <= 1'b0;
            match_hit_q <= 1'b0;
            match_out_q <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state     <= READY;
                        dst_rdy_q <= 1'b1;
                    end
                end
                READY: begin
                    dst_rdy_q <= 1'b1;
                end
                default: begin
                    state     <= INIT;
                    clr_cnt   <= '0;
                    dst_rdy_q <= 1'b0;
                end
            endcase

            if ((state == READY) && wb.MATCH_REQ) begin
                match_vld_q <= 1'b1;
                match_out_q <= hit_vec;
                match_hit_q <= |hit_vec;
            end else begin
                match_vld_q <= 1'b0;
                match_out_q <= '0;
                match_hit_q <= 1'b0;
            end
        end
    end

    assign wb.WB_DST_RDY = dst_rdy_q;
    assign wb.MATCH_VLD  = match_vld_q;
    assign wb.MATCH_HIT  = match_hit_q;
    assign wb.MATCH_OUT  = match_out_q;

endmodule

// File: tb/tb_wb_tcam_write_ctrl.sv
// Directed bench for the ternary match table with an 8-entry, 8-bit configuration.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every expected value below is worked out by hand from the table contents.
module tb_wb_tcam_write_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    wb_tcam_write_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

    wb_tcam_write_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .wb    (wb)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW-1:0] mask);
        wb.WB_ADDR    = addr;
        wb.WB_DATA    = data;
        wb.WB_MASK    = mask;
        wb.WB_SRC_RDY = 1'b1;
        step();
        wb.WB_SRC_RDY = 1'b0;
    endtask

    task automatic do_lookup(input logic [DW-1:0] key);
        wb.MATCH_KEY = key;
        wb.MATCH_REQ = 1'b1;
        step();
        wb.MATCH_REQ = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        step();
        step();
        vectors++; if (wb.WB_DST_RDY !== 1'b0) begin miscompares++; $display("FAIL rst_dst_rdy got %b want 0", wb.WB_DST_RDY); end
        vectors++; if (wb.MATCH_VLD !== 1'b0) begin miscompares++; $display("FAIL rst_vld got %b want 0", wb.MATCH_VLD); end
        vectors++; if (wb.MATCH_HIT !== 1'b0) begin miscompares++; $display("FAIL rst_hit got %b want 0", wb.MATCH_HIT); end
        vectors++; if (wb.MATCH_OUT !== 8'h00) begin miscompares++; $display("FAIL rst_out got %h want 00", wb.MATCH_OUT); end
        RESET = 1'b1;
        // Eight samples of DST_RDY=0 (before edge 1 and after edges 1..7), then 1 after edge 8.
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            vectors++; if (wb.WB_DST_RDY !== 1'b0) begin miscompares++; $display("FAIL init_dst_rdy[%0d] got %b want 0", k, wb.WB_DST_RDY); end
        end
        step();
        vectors++; if (wb.WB_DST_RDY !== 1'b1) begin miscompares++; $display("FAIL ready_dst_rdy got %b want 1", wb.WB_DST_RDY); end
    endtask

    task automatic test_exact_match();
        do_write(3'd2, 8'hAB, 8'hFF);
        do_lookup(8'hAB);
        vectors++; if (wb.MATCH_VLD !== 1'b1) begin miscompares++; $display("FAIL exact_vld got %b want 1", wb.MATCH_VLD); end
        vectors++; if (wb.MATCH_OUT !== 8'h04) begin miscompares++; $display("FAIL exact_out got %h want 04", wb.MATCH_OUT); end
        vectors++; if (wb.MATCH_HIT !== 1'b1) begin miscompares++; $display("FAIL exact_hit got %b want 1", wb.MATCH_HIT); end
        do_lookup(8'hAC);
        vectors++; if (wb.MATCH_VLD !== 1'b1) begin miscompares++; $display("FAIL miss_vld got %b want 1", wb.MATCH_VLD); end
        vectors++; if (wb.MATCH_HIT !== 1'b0) begin miscompares++; $display("FAIL miss_hit got %b want 0", wb.MATCH_HIT); end
        vectors++; if (wb.MATCH_OUT !== 8'h00) begin miscompares++; $display("FAIL miss_out got %h want 00", wb.MATCH_OUT); end
        step();
        vectors++; if (wb.MATCH_VLD !== 1'b0) begin miscompares++; $display("FAIL idle_vld got %b want 0", wb.MATCH_VLD); end
        vectors++; if (wb.MATCH_OUT !== 8'h00) begin miscompares++; $display("FAIL idle_out got %h want 00", wb.MATCH_OUT); end
    endtask

    task automatic test_ternary();
        do_write(3'd5, 8'hA0, 8'hF0);
        do_lookup(8'hA7);
        vectors++; if (wb.MATCH_OUT !== 8'h20) begin miscompares++; $display("FAIL tern_out got %h want 20", wb.MATCH_OUT); end
        vectors++; if (wb.MATCH_HIT !== 1'b1) begin miscompares++; $display("FAIL tern_hit got %b want 1", wb.MATCH_HIT); end
        do_write(3'd6, 8'h5A, 8'h00);
        do_lookup(8'hA3);
        vectors++; if (wb.MATCH_OUT !== 8'h60) begin miscompares++; $display("FAIL wild_a3 got %h want 60", wb.MATCH_OUT); end
        do_lookup(8'hAB);
        vectors++; if (wb.MATCH_OUT !== 8'h64) begin miscompares++; $display("FAIL wild_ab got %h want 64", wb.MATCH_OUT); end
        do_lookup(8'h00);
        vectors++; if (wb.MATCH_OUT !== 8'h40) begin miscompares++; $display("FAIL wild_00 got %h want 40", wb.MATCH_OUT); end
    endtask

    task automatic test_same_cycle();
        wb.WB_ADDR    = 3'd1;
        wb.WB_DATA    = 8'h11;
        wb.WB_MASK    = 8'hFF;
        wb.WB_SRC_RDY = 1'b1;
        wb.MATCH_KEY  = 8'h11;
        wb.MATCH_REQ  = 1'b1;
        step();
        wb.WB_SRC_RDY = 1'b0;
        wb.MATCH_REQ  = 1'b0;
        vectors++; if (wb.MATCH_OUT !== 8'h40) begin miscompares++; $display("FAIL same_old got %h want 40", wb.MATCH_OUT); end
        do_lookup(8'h11);
        vectors++; if (wb.MATCH_OUT !== 8'h42) begin miscompares++; $display("FAIL same_new got %h want 42", wb.MATCH_OUT); end
    endtask

    task automatic test_back_to_back();
        wb.MATCH_REQ = 1'b1;
        wb.MATCH_KEY = 8'hAB;
        step();
        vectors++; if (wb.MATCH_OUT !== 8'h64 || wb.MATCH_VLD !== 1'b1) begin miscompares++; $display("FAIL b2b_0 got %h/%b want 64/1", wb.MATCH_OUT, wb.MATCH_VLD); end
        wb.MATCH_KEY = 8'h11;
        step();
        vectors++; if (wb.MATCH_OUT !== 8'h42 || wb.MATCH_VLD !== 1'b1) begin miscompares++; $display("FAIL b2b_1 got %h/%b want 42/1", wb.MATCH_OUT, wb.MATCH_VLD); end
        wb.MATCH_KEY = 8'hA5;
        step();
        vectors++; if (wb.MATCH_OUT !== 8'h60 || wb.MATCH_VLD !== 1'b1) begin miscompares++; $display("FAIL b2b_2 got %h/%b want 60/1", wb.MATCH_OUT, wb.MATCH_VLD); end
        wb.MATCH_REQ = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Lookup presented together with reset: no result may come out.
        wb.MATCH_KEY = 8'hAB;
        wb.MATCH_REQ = 1'b1;
        RESET = 1'b0;
        step();
        vectors++; if (wb.MATCH_VLD !== 1'b0) begin miscompares++; $display("FAIL abort_vld got %b want 0", wb.MATCH_VLD); end
        vectors++; if (wb.MATCH_OUT !== 8'h00) begin miscompares++; $display("FAIL abort_out got %h want 00", wb.MATCH_OUT); end
        vectors++; if (wb.WB_DST_RDY !== 1'b0) begin miscompares++; $display("FAIL abort_dst_rdy got %b want 0", wb.WB_DST_RDY); end
        RESET = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++; if (wb.MATCH_VLD !== 1'b0) begin miscompares++; $display("FAIL init_lookup[%0d] got %b want 0", k, wb.MATCH_VLD); end
        end
        step();
        vectors++; if (wb.MATCH_VLD !== 1'b1 || wb.MATCH_HIT !== 1'b0) begin miscompares++; $display("FAIL reinit_ab got %b/%b want 1/0", wb.MATCH_VLD, wb.MATCH_HIT); end
        wb.MATCH_KEY = 8'h11;
        step();
        vectors++; if (wb.MATCH_HIT !== 1'b0 || wb.MATCH_OUT !== 8'h00) begin miscompares++; $display("FAIL reinit_11 got %b/%h want 0/00", wb.MATCH_HIT, wb.MATCH_OUT); end
        wb.MATCH_KEY = 8'hA3;
        step();
        vectors++; if (wb.MATCH_HIT !== 1'b0 || wb.MATCH_OUT !== 8'h00) begin miscompares++; $display("FAIL reinit_a3 got %b/%h want 0/00", wb.MATCH_HIT, wb.MATCH_OUT); end
        wb.MATCH_REQ = 1'b0;
    endtask

    task automatic test_init_hold();
        int n;
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        wb.WB_ADDR    = 3'd3;
        wb.WB_DATA    = 8'h33;
        wb.WB_MASK    = 8'hFF;
        wb.WB_SRC_RDY = 1'b1;
        n = 0;
        while (wb.WB_DST_RDY !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++; if (n != 8) begin miscompares++; $display("FAIL hold_wait got %0d cycles want 8", n); end
        step();
        wb.WB_SRC_RDY = 1'b0;
        do_lookup(8'h33);
        vectors++; if (wb.MATCH_OUT !== 8'h08 || wb.MATCH_HIT !== 1'b1) begin miscompares++; $display("FAIL hold_hit got %h/%b want 08/1", wb.MATCH_OUT, wb.MATCH_HIT); end
        do_lookup(8'h34);
        vectors++; if (wb.MATCH_OUT !== 8'h00 || wb.MATCH_HIT !== 1'b0) begin miscompares++; $display("FAIL hold_miss got %h/%b want 00/0", wb.MATCH_OUT, wb.MATCH_HIT); end
    endtask

    initial begin
        RESET         = 1'b0;
        wb.WB_DATA    = '0;
        wb.WB_MASK    = '0;
        wb.WB_ADDR    = '0;
        wb.WB_SRC_RDY = 1'b0;
        wb.MATCH_KEY  = '0;
        wb.MATCH_REQ  = 1'b0;

        test_reset();
        test_exact_match();
        test_ternary();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_init_hold();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
